// File: rtl/cordic_fm_demod.sv
// Sequential vectoring-mode CORDIC FM discriminator: one micro-rotation per clock,
// reports phase, unnormalised magnitude and wrapped phase delta per I/Q sample.
module cordic_fm_demod #(
    parameter int unsigned BITS = 16,
    parameter int unsigned ITER = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] in_i,
    input  logic signed [BITS-1:0] in_q,
    output logic                   out_valid,
    output logic [31:0]            out_phase,
    output logic [31:0]            out_freq,
    output logic [BITS:0]          out_mag
);
    localparam int unsigned W = BITS + 2;
    localparam logic [4:0] LastK = 5'(ITER - 1);

    typedef enum logic {StIdle, StRot} state_t;

    state_t               state;
    logic [4:0]           k;
    logic signed [W-1:0]  x, y;
    logic [31:0]          z;
    logic [31:0]          prev_phase;
    logic                 primed;
    logic                 zero;

    logic signed [W-1:0]  i_ext, q_ext, pre_x, pre_y;
    logic [31:0]          pre_z;
    logic signed [W-1:0]  x_sh, y_sh, x_rot, y_rot;
    logic [31:0]          z_rot, atan_k, phase_fin;

    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:  atan_lut = 32'h2000_0000;
            5'd1:  atan_lut = 32'h12E4_051D;
            5'd2:  atan_lut = 32'h09FB_385B;
            5'd3:  atan_lut = 32'h0511_11D4;
            5'd4:  atan_lut = 32'h028B_0D43;
            5'd5:  atan_lut = 32'h0145_D7E1;
            5'd6:  atan_lut = 32'h00A2_F61E;
            5'd7:  atan_lut = 32'h0051_7C55;
            5'd8:  atan_lut = 32'h0028_BE53;
            5'd9:  atan_lut = 32'h0014_5F2E;
            5'd10: atan_lut = 32'h000A_2F98;
            5'd11: atan_lut = 32'h0005_17CC;
            5'd12: atan_lut = 32'h0002_8BE6;
            5'd13: atan_lut = 32'h0001_45F3;
            5'd14: atan_lut = 32'h0000_A2F9;
            5'd15: atan_lut = 32'h0000_517C;
            5'd16: atan_lut = 32'h0000_28BE;
            5'd17: atan_lut = 32'h0000_145F;
            5'd18: atan_lut = 32'h0000_0A2F;
            5'd19: atan_lut = 32'h0000_0517;
            5'd20: atan_lut = 32'h0000_028B;
            5'd21: atan_lut = 32'h0000_0145;
            5'd22: atan_lut = 32'h0000_00A2;
            5'd23: atan_lut = 32'h0000_0051;
            5'd24: atan_lut = 32'h0000_0028;
            5'd25: atan_lut = 32'h0000_0014;
            5'd26: atan_lut = 32'h0000_000A;
            5'd27: atan_lut = 32'h0000_0005;
            5'd28: atan_lut = 32'h0000_0002;
            5'd29: atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    assign in_ready = reset && (state == StIdle);

    // Fold the left half-plane onto the right so the iterations always converge.
    always_comb begin
        i_ext = W'(in_i);
        q_ext = W'(in_q);
        pre_x = i_ext;
        pre_y = q_ext;
        pre_z = 32'h0000_0000;
        if (in_i[BITS-1]) begin
            if (!in_q[BITS-1]) begin
                pre_x = q_ext;
                pre_y = -i_ext;
                pre_z = 32'h4000_0000;
            end else begin
                pre_x = -q_ext;
                pre_y = i_ext;
                pre_z = 32'hC000_0000;
            end
        end
    end

    always_comb begin
        atan_k = atan_lut(k);
        x_sh   = x >>> k;
        y_sh   = y >>> k;
        if (y[W-1]) begin
            x_rot = x - y_sh;
            y_rot = y + x_sh;
            z_rot = z - atan_k;
        end else begin
            x_rot = x + y_sh;
            y_rot = y - x_sh;
            z_rot = z + atan_k;
        end
        // A zero vector has no defined angle; report 0 rather than the accumulated table sum.
        phase_fin = zero ? 32'h0000_0000 : z_rot;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            k          <= '0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            zero       <= 1'b0;
            prev_phase <= '0;
            primed     <= 1'b0;
            out_valid  <= 1'b0;
            out_phase  <= '0;
            out_freq   <= '0;
            out_mag    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        x     <= pre_x;
                        y     <= pre_y;
                        z     <= pre_z;
                        zero  <= (in_i == '0) && (in_q == '0);
                        k     <= '0;
                        state <= StRot;
                    end
                end
                StRot: begin
                    x <= x_rot;
                    y <= y_rot;
                    z <= z_rot;
                    k <= k + 5'd1;
                    if (k == LastK) begin
                        out_phase  <= phase_fin;
                        out_mag    <= x_rot[W-1] ? '0 : x_rot[BITS:0];
                        out_freq   <= primed ? (phase_fin - prev_phase) : 32'h0000_0000;
                        prev_phase <= phase_fin;
                        primed     <= 1'b1;
                        out_valid  <= 1'b1;
                        k          <= '0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_fm_demod.sv
// Bench for cordic_fm_demod: floating-point atan2/hypot reference model, randomized and
// directed samples, handshake spacing and mid-operation reset.
module tb_cordic_fm_demod;
    localparam int BITS = 16;
    localparam int ITER = 16;
    localparam int PH_TOL = 1 << 18;
    localparam int FR_TOL = 1 << 19;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [BITS-1:0] in_i = '0;
    logic signed [BITS-1:0] in_q = '0;
    logic                   out_valid;
    logic [31:0]            out_phase;
    logic [31:0]            out_freq;
    logic [BITS:0]          out_mag;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit          m_primed = 1'b0;
    logic [31:0] m_prev = '0;

    cordic_fm_demod #(.BITS(BITS), .ITER(ITER)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_phase (out_phase),
        .out_freq  (out_freq),
        .out_mag   (out_mag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ref_phase(input int i, input int q);
        real a;
        longint r;
        logic [63:0] w;
        if (i == 0 && q == 0) return 32'h0;
        a = $atan2(real'(q), real'(i)) * 4294967296.0 / (2.0 * 3.14159265358979);
        r = longint'(a);
        w = r;
        return w[31:0];
    endfunction

    function automatic int ref_mag(input int i, input int q);
        return int'(1.64676 * $sqrt(real'(i) * real'(i) + real'(q) * real'(q)));
    endfunction

    function automatic int ang_err(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        int e;
        d = a - b;
        e = $signed(d);
        return (e < 0) ? -e : e;
    endfunction

    task automatic model_step(input int i, input int q, output logic [31:0] ph,
                              output logic [31:0] fr);
        ph = ref_phase(i, q);
        fr = m_primed ? ph - m_prev : 32'h0;
        m_prev = ph;
        m_primed = 1'b1;
    endtask

    task automatic rand_point(output int i, output int q);
        longint r2;
        do begin
            i = int'($urandom_range(65535)) - 32768;
            q = int'($urandom_range(65535)) - 32768;
            r2 = longint'(i) * i + longint'(q) * q;
        end while (r2 < 64'sd268435456);
    endtask

    // Present one sample, wait for its result; lat = -1 if it never arrives.
    task automatic run_sample(input int i, input int q, input bit disturb,
                              output logic [31:0] ph, output logic [31:0] fr,
                              output logic [BITS:0] mg, output int lat);
        int n, acc;
        in_i = BITS'(i);
        in_q = BITS'(q);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        acc = cyc;
        in_valid = 1'b0;
        lat = -1;
        ph = '0;
        fr = '0;
        mg = '0;
        for (int c = 1; c <= 64; c++) begin
            if (disturb) begin
                in_i = BITS'($urandom);
                in_q = BITS'($urandom);
                in_valid = (c == 5);
            end
            @(posedge clock); #1;
            if (out_valid) begin
                lat = cyc - acc;
                ph = out_phase;
                fr = out_freq;
                mg = out_mag;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b want 0", in_ready);
        end
        vectors++;
        if ({out_valid, out_phase, out_freq, out_mag} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b ph=%h fr=%h mag=%0d want all 0",
                     out_valid, out_phase, out_freq, out_mag);
        end
        reset = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (out_valid) pulses++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready_high: got %b want 1", in_ready);
        end
        vectors++;
        if (pulses != 0 || {out_phase, out_freq, out_mag} !== '0) begin
            miscompares++;
            $display("FAIL idle_quiet: got pulses=%0d ph=%h fr=%h mag=%0d want 0",
                     pulses, out_phase, out_freq, out_mag);
        end
        m_primed = 1'b0;
        m_prev = '0;
    endtask

    task automatic test_axis();
        int pts_i[4] = '{16384, 0, -16384, 0};
        int pts_q[4] = '{0, 16384, 0, -16384};
        logic [31:0] want_ph[4] = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        logic [31:0] eph, efr, ph, fr;
        logic [BITS:0] mg;
        int lat;
        for (int n = 0; n < 4; n++) begin
            model_step(pts_i[n], pts_q[n], eph, efr);
            run_sample(pts_i[n], pts_q[n], 1'b0, ph, fr, mg, lat);
            vectors++;
            if (lat != ITER) begin
                miscompares++;
                $display("FAIL axis_latency[%0d]: got %0d want %0d", n, lat, ITER);
            end
            vectors++;
            if (ang_err(ph, want_ph[n]) > PH_TOL) begin
                miscompares++;
                $display("FAIL axis_phase[%0d]: got %h want %h", n, ph, want_ph[n]);
            end
            if (n == 0) begin
                vectors++;
                if (mg > 26985 || mg < 26977) begin
                    miscompares++;
                    $display("FAIL axis_mag: got %0d want 26981+-4", mg);
                end
                vectors++;
                if (fr !== 32'h0) begin
                    miscompares++;
                    $display("FAIL axis_first_freq: got %h want 0", fr);
                end
            end else begin
                vectors++;
                if (ang_err(fr, efr) > FR_TOL) begin
                    miscompares++;
                    $display("FAIL axis_freq[%0d]: got %h want %h", n, fr, efr);
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic [31:0] eph, efr, ph, fr;
        logic [BITS:0] mg;
        int lat, si, sq;
        real ang;
        for (int n = 0; n < 16; n++) begin
            ang = (22.5 + 45.0 * n) * 3.14159265358979 / 180.0;
            si = int'(16000.0 * $cos(ang));
            sq = int'(16000.0 * $sin(ang));
            model_step(si, sq, eph, efr);
            run_sample(si, sq, 1'b0, ph, fr, mg, lat);
            vectors++;
            if (ang_err(ph, eph) > PH_TOL || lat != ITER) begin
                miscompares++;
                $display("FAIL rot_phase[%0d]: got %h lat %0d want %h lat %0d",
                         n, ph, lat, eph, ITER);
            end
            if (n > 0) begin
                vectors++;
                if (ang_err(fr, 32'h2000_0000) > FR_TOL) begin
                    miscompares++;
                    $display("FAIL rot_freq[%0d]: got %h want 20000000", n, fr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int hi[3], hq[3], acc_t[3];
        logic [31:0] eph[3], efr, obs[3], ph, fr;
        logic [BITS:0] mg;
        int nacc, nout, lat, si, sq;
        bit rdy;
        for (int n = 0; n < 3; n++) begin
            rand_point(hi[n], hq[n]);
            model_step(hi[n], hq[n], eph[n], efr);
        end
        in_i = BITS'(hi[0]);
        in_q = BITS'(hq[0]);
        in_valid = 1'b1;
        nacc = 0;
        nout = 0;
        for (int c = 0; c < 100 && nout < 3; c++) begin
            rdy = in_ready;
            @(posedge clock); #1;
            if (rdy && nacc < 3) begin
                acc_t[nacc] = cyc;
                nacc++;
                if (nacc < 3) begin
                    in_i = BITS'(hi[nacc]);
                    in_q = BITS'(hq[nacc]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                obs[nout] = out_phase;
                nout++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (nout != 3 || nacc != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got acc=%0d out=%0d want 3/3", nacc, nout);
        end else begin
            for (int n = 0; n < 3; n++) begin
                vectors++;
                if (ang_err(obs[n], eph[n]) > PH_TOL) begin
                    miscompares++;
                    $display("FAIL b2b_phase[%0d]: got %h want %h", n, obs[n], eph[n]);
                end
            end
            for (int n = 1; n < 3; n++) begin
                vectors++;
                if (acc_t[n] - acc_t[n-1] != ITER + 1) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d",
                             n, acc_t[n] - acc_t[n-1], ITER + 1);
                end
            end
        end
        // Inputs scrambled and in_valid pulsed while busy.
        for (int n = 0; n < 2; n++) begin
            rand_point(si, sq);
            model_step(si, sq, eph[0], efr);
            run_sample(si, sq, 1'b1, ph, fr, mg, lat);
            vectors++;
            if (lat != ITER || ang_err(ph, eph[0]) > PH_TOL ||
                ang_err(fr, efr) > FR_TOL) begin
                miscompares++;
                $display("FAIL busy_ignore[%0d]: got lat=%0d ph=%h fr=%h want lat=%0d ph=%h fr=%h",
                         n, lat, ph, fr, ITER, eph[0], efr);
            end
            vectors++;
            if (mg > ref_mag(si, sq) + 8 || mg + 8 < ref_mag(si, sq)) begin
                miscompares++;
                $display("FAIL busy_mag[%0d]: got %0d want %0d+-8", n, mg, ref_mag(si, sq));
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses, lat, si, sq;
        logic [31:0] eph, efr, ph, fr;
        logic [BITS:0] mg;
        in_i = BITS'(12000);
        in_q = BITS'(-9000);
        in_valid = 1'b1;
        while (!in_ready) begin
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset = 1'b0;
        pulses = 0;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got ready=%b valid=%b want 0/0", in_ready, out_valid);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (20) begin
            @(posedge clock); #1;
            if (out_valid) pulses++;
        end
        vectors++;
        if (pulses != 0 || {out_phase, out_freq, out_mag} !== '0) begin
            miscompares++;
            $display("FAIL midreset_no_output: got pulses=%0d ph=%h fr=%h mag=%0d want 0",
                     pulses, out_phase, out_freq, out_mag);
        end
        m_primed = 1'b0;
        m_prev = '0;
        rand_point(si, sq);
        model_step(si, sq, eph, efr);
        run_sample(si, sq, 1'b0, ph, fr, mg, lat);
        vectors++;
        if (fr !== 32'h0 || lat != ITER || ang_err(ph, eph) > PH_TOL) begin
            miscompares++;
            $display("FAIL midreset_unprimed: got fr=%h lat=%0d ph=%h want fr=0 lat=%0d ph=%h",
                     fr, lat, ph, ITER, eph);
        end
    endtask

    task automatic test_full_scale();
        logic [31:0] eph, efr, ph, fr;
        logic [BITS:0] mg;
        int lat;
        model_step(-32768, -32768, eph, efr);
        run_sample(-32768, -32768, 1'b0, ph, fr, mg, lat);
        vectors++;
        if (ang_err(ph, 32'hA000_0000) > PH_TOL || lat != ITER) begin
            miscompares++;
            $display("FAIL fs_phase: got %h lat %0d want a0000000 lat %0d", ph, lat, ITER);
        end
        vectors++;
        if (mg > 76322 || mg < 76306) begin
            miscompares++;
            $display("FAIL fs_mag: got %0d want 76314+-8", mg);
        end
        model_step(-32768, 0, eph, efr);
        run_sample(-32768, 0, 1'b0, ph, fr, mg, lat);
        vectors++;
        if (ang_err(ph, eph) > PH_TOL || mg > ref_mag(-32768, 0) + 8 ||
            mg + 8 < ref_mag(-32768, 0)) begin
            miscompares++;
            $display("FAIL fs_180: got ph=%h mag=%0d want ph=%h mag=%0d", ph, mg, eph,
                     ref_mag(-32768, 0));
        end
        model_step(0, 0, eph, efr);
        run_sample(0, 0, 1'b0, ph, fr, mg, lat);
        vectors++;
        if (ph !== 32'h0 || mg !== '0) begin
            miscompares++;
            $display("FAIL zero_input: got ph=%h mag=%0d want 0/0", ph, mg);
        end
        vectors++;
        if (ang_err(fr, efr) > FR_TOL) begin
            miscompares++;
            $display("FAIL zero_freq: got %h want %h", fr, efr);
        end
    endtask

    task automatic test_random();
        logic [31:0] eph, efr, ph, fr;
        logic [BITS:0] mg;
        int lat, si, sq, em;
        for (int n = 0; n < 24; n++) begin
            rand_point(si, sq);
            model_step(si, sq, eph, efr);
            em = ref_mag(si, sq);
            run_sample(si, sq, 1'b0, ph, fr, mg, lat);
            vectors++;
            if (lat != ITER || ang_err(ph, eph) > PH_TOL) begin
                miscompares++;
                $display("FAIL rand_phase[%0d] (%0d,%0d): got %h lat %0d want %h", n, si, sq,
                         ph, lat, eph);
            end
            vectors++;
            if (int'(mg) > em + 8 || int'(mg) < em - 8) begin
                miscompares++;
                $display("FAIL rand_mag[%0d] (%0d,%0d): got %0d want %0d+-8", n, si, sq, mg, em);
            end
            vectors++;
            if (ang_err(fr, efr) > FR_TOL) begin
                miscompares++;
                $display("FAIL rand_freq[%0d]: got %h want %h", n, fr, efr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_axis();
        test_rotation();
        test_back_to_back();
        test_reset_mid();
        test_full_scale();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
